// File: rtl/contador_param.sv
// contador_param: parametrised synchronous counter-register.
//
// Counts up by 1, down by 1, up by STEP, or loads a parallel value, selected
// by modo. Both q and rco are registered, so instances cascade by driving the
// next stage's enb from this stage's rco.
//
// Parameters:
//   WIDTH    counter/data width in bits (>= 2)
//   STEP     increment used for modo = 2'b10 (1 .. 2**WIDTH-1)
//   SATURATE 0: wrap modulo 2**WIDTH; 1: clamp at all-ones / zero
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous reset, active-high (q = 0, rco = 0)
//   enb    in   enable; 0 freezes q and clears rco
//   modo   in   00 up 1, 01 down 1, 10 up STEP, 11 load d
//   d      in   parallel load value
//   q      out  registered count
//   rco    out  registered carry/borrow (or clamp) flag

module contador_param #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned STEP     = 3,
    parameter int unsigned SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enb,
    input  logic [1:0]       modo,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             rco
);

    localparam logic [1:0] MODO_UP   = 2'b00;
    localparam logic [1:0] MODO_DOWN = 2'b01;
    localparam logic [1:0] MODO_STEP = 2'b10;
    localparam logic [1:0] MODO_LOAD = 2'b11;

    localparam bit             SAT    = (SATURATE != 0);
    localparam logic [WIDTH:0] ONE_W  = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0] STEP_W = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH - 1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_q, q_d;
    logic             rco_q, rco_d;
    logic [WIDTH:0]   sum_up, sum_step;

    // One extra bit holds the carry out of the increment.
    assign sum_up   = {1'b0, q_q} + ONE_W;
    assign sum_step = {1'b0, q_q} + STEP_W;

    always_comb begin
        q_d   = q_q;
        rco_d = 1'b0;
        if (enb) begin
            unique case (modo)
                MODO_UP: begin
                    rco_d = sum_up[WIDTH];
                    if (sum_up[WIDTH] && SAT) begin
                        q_d = '1;
                    end else begin
                        q_d = sum_up[WIDTH-1:0];
                    end
                end
                MODO_DOWN: begin
                    if (q_q == '0) begin
                        // Borrow: wrap to all-ones or clamp at zero.
                        rco_d = 1'b1;
                        q_d   = SAT ? '0 : '1;
                    end else begin
                        q_d = q_q - ONE;
                    end
                end
                MODO_STEP: begin
                    rco_d = sum_step[WIDTH];
                    if (sum_step[WIDTH] && SAT) begin
                        q_d = '1;
                    end else begin
                        q_d = sum_step[WIDTH-1:0];
                    end
                end
                MODO_LOAD: begin
                    q_d = d;
                end
                default: begin
                    q_d = q_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q   <= '0;
            rco_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            rco_q <= rco_d;
        end
    end

    assign q   = q_q;
    assign rco = rco_q;

endmodule

// File: tb/tb_contador_param.sv
// Bench for contador_param: a 4-bit wrapping instance (STEP=3) and an 8-bit
// saturating instance (STEP=3) share control inputs. The driver pushes the
// reference model's expected outputs into a queue; a monitor pops one entry
// per clock and compares both instances.

module tb_contador_param;

    logic       clk;
    logic       reset;
    logic       enb;
    logic [1:0] modo;
    logic [7:0] d8;
    logic [3:0] q4;
    logic       rco4;
    logic [7:0] q8;
    logic       rco8;

    contador_param #(.WIDTH(4), .STEP(3), .SATURATE(0)) dut4 (
        .clk   (clk),
        .reset (reset),
        .enb   (enb),
        .modo  (modo),
        .d     (d8[3:0]),
        .q     (q4),
        .rco   (rco4)
    );

    contador_param #(.WIDTH(8), .STEP(3), .SATURATE(1)) dut8 (
        .clk   (clk),
        .reset (reset),
        .enb   (enb),
        .modo  (modo),
        .d     (d8),
        .q     (q8),
        .rco   (rco8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int q4;
        bit r4;
        int q8;
        bit r8;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   m4 = 0;
    int   m8 = 0;

    // Reference model: plain integer arithmetic on the count value.
    function automatic void ref_step(input int w, input int stp, input bit sat,
                                     input bit r, input bit e, input logic [1:0] m,
                                     input int dv, input int cur,
                                     output int nxt, output bit rc);
        int lim;
        int s;
        lim = 1 << w;
        nxt = cur;
        rc  = 1'b0;
        if (r) begin
            nxt = 0;
        end else if (e) begin
            case (m)
                2'd0, 2'd2: begin
                    s = cur + ((m == 2'd0) ? 1 : stp);
                    if (s >= lim) begin
                        rc  = 1'b1;
                        nxt = sat ? lim - 1 : s - lim;
                    end else begin
                        nxt = s;
                    end
                end
                2'd1: begin
                    if (cur == 0) begin
                        rc  = 1'b1;
                        nxt = sat ? 0 : lim - 1;
                    end else begin
                        nxt = cur - 1;
                    end
                end
                default: nxt = dv % lim;
            endcase
        end
    endfunction

    task automatic drive(input bit r, input bit e, input logic [1:0] m, input logic [7:0] dv);
        exp_t x;
        int   n4;
        int   n8;
        bit   c4;
        bit   c8;
        @(negedge clk);
        #1;
        reset = r;
        enb   = e;
        modo  = m;
        d8    = dv;
        ref_step(4, 3, 1'b0, r, e, m, int'(dv), m4, n4, c4);
        ref_step(8, 3, 1'b1, r, e, m, int'(dv), m8, n8, c8);
        m4   = n4;
        m8   = n8;
        x.q4 = n4;
        x.r4 = c4;
        x.q8 = n8;
        x.r8 = c8;
        sb.push_back(x);
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: entries pushed before the preceding rising edge are due now.
    always @(negedge clk) begin
        exp_t x;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            check("q4", int'(q4), x.q4);
            check("rco4", int'(rco4), int'(x.r4));
            check("q8", int'(q8), x.q8);
            check("rco8", int'(rco8), int'(x.r8));
        end
    end

    initial begin
        reset = 1'b1;
        enb   = 1'b0;
        modo  = 2'b00;
        d8    = 8'h00;

        // Reset, then count up through the 4-bit wrap.
        drive(1, 0, 2'b00, 8'h00);
        drive(0, 1, 2'b11, 8'h00);
        for (int i = 0; i < 16; i++) drive(0, 1, 2'b00, 8'h00);

        // Down-count borrow from zero.
        drive(0, 1, 2'b11, 8'h00);
        for (int i = 0; i < 3; i++) drive(0, 1, 2'b01, 8'h00);

        // STEP increments through the wrap.
        drive(0, 1, 2'b11, 8'h00);
        for (int i = 0; i < 6; i++) drive(0, 1, 2'b10, 8'h00);

        // Disabled edges ignore a pending load.
        drive(0, 1, 2'b11, 8'h04);
        drive(0, 1, 2'b00, 8'h00);
        for (int i = 0; i < 3; i++) drive(0, 0, 2'b11, 8'h09);
        drive(0, 1, 2'b00, 8'h00);

        // Reset mid-count beats a load; counting resumes from zero.
        drive(0, 1, 2'b11, 8'h07);
        drive(1, 1, 2'b11, 8'h0C);
        drive(0, 1, 2'b00, 8'h00);

        // Saturation at the top, then at the bottom.
        drive(0, 1, 2'b11, 8'hFE);
        for (int i = 0; i < 3; i++) drive(0, 1, 2'b00, 8'h00);
        drive(0, 1, 2'b10, 8'h00);
        drive(0, 1, 2'b11, 8'h01);
        for (int i = 0; i < 2; i++) drive(0, 1, 2'b01, 8'h00);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(31) == 0), ($urandom_range(4) != 0),
                  2'($urandom_range(3)), 8'($urandom));
        end

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
